mem_wb_stage: RTL and testbench

MEM/WB pipeline stage of the pipelined CPU. Captures the EX/MEM result and data-memory read word, aligns load data and generates per-byte write enables (including partial LWL/LWR writes). Presents the registered `memwb_*` write-back triple to the register file and the forwarding unit. Also flags misaligned loads and counts retired instructions.

---
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: aligns load data, builds per-byte write enables,
// flags misaligned loads and counts retired instructions.
module mem_wb_stage #(
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_valid,
    input  logic [4:0]  exmem_rd_addr,
    input  logic [3:0]  exmem_byte_en,
    input  logic [31:0] exmem_result,
    input  logic        exmem_mem_read,
    input  logic [2:0]  exmem_load_op,
    input  logic [31:0] dmem_rdata,
    output logic        memwb_valid,
    output logic [4:0]  memwb_rd_addr,
    output logic [3:0]  memwb_byte_en,
    output logic [31:0] memwb_data,
    output logic        memwb_misalign,
    output logic [31:0] retire_cnt
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_LWL = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;

    // LW (and the reserved encoding) need word alignment, halfwords need even addresses.
    function automatic logic load_misalign(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: load_misalign = 1'b0;
            OP_LH, OP_LHU:                 load_misalign = a[0];
            default:                       load_misalign = (a != 2'd0);
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = rdata[8*a +: 8];
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            OP_LWL: begin
                case (a)
                    2'd0:    load_data = {rdata[7:0], 24'd0};
                    2'd1:    load_data = {rdata[15:0], 16'd0};
                    2'd2:    load_data = {rdata[23:0], 8'd0};
                    default: load_data = rdata;
                endcase
            end
            OP_LWR: begin
                case (a)
                    2'd0:    load_data = rdata;
                    2'd1:    load_data = {8'd0, rdata[31:8]};
                    2'd2:    load_data = {16'd0, rdata[31:16]};
                    default: load_data = {24'd0, rdata[31:24]};
                endcase
            end
            default: load_data = rdata;
        endcase
    endfunction

    function automatic logic [3:0] load_be(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_LWL: begin
                case (a)
                    2'd0:    load_be = 4'b1000;
                    2'd1:    load_be = 4'b1100;
                    2'd2:    load_be = 4'b1110;
                    default: load_be = 4'b1111;
                endcase
            end
            OP_LWR: begin
                case (a)
                    2'd0:    load_be = 4'b1111;
                    2'd1:    load_be = 4'b0111;
                    2'd2:    load_be = 4'b0011;
                    default: load_be = 4'b0001;
                endcase
            end
            default: load_be = 4'b1111;
        endcase
    endfunction

    logic [1:0]  addr_lo_p0;
    logic        mis_p0;
    logic [31:0] data_p0;
    logic [3:0]  be_p0;
    logic        retire_p0;

    // Stage p0: combinational alignment of the EX/MEM fields
    always_comb begin
        addr_lo_p0 = exmem_result[1:0];
        mis_p0     = exmem_valid && exmem_mem_read && load_misalign(exmem_load_op, addr_lo_p0);
        data_p0    = exmem_result;
        be_p0      = exmem_byte_en;
        if (exmem_mem_read) begin
            if (mis_p0) begin
                data_p0 = dmem_rdata;
            end else begin
                data_p0 = load_data(exmem_load_op, addr_lo_p0, dmem_rdata);
            end
            be_p0 = load_be(exmem_load_op, addr_lo_p0);
        end
        if (mis_p0 || !exmem_valid || (ZERO_SUPPRESS && exmem_rd_addr == 5'd0)) begin
            be_p0 = 4'b0000;
        end
        retire_p0 = exmem_valid && !mis_p0;
    end

    // Stage p1: registered write-back triple and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_valid    <= 1'b0;
            memwb_rd_addr  <= 5'd0;
            memwb_byte_en  <= 4'b0000;
            memwb_data     <= 32'd0;
            memwb_misalign <= 1'b0;
            retire_cnt     <= 32'd0;
        end else if (flush) begin
            memwb_valid    <= 1'b0;
            memwb_rd_addr  <= 5'd0;
            memwb_byte_en  <= 4'b0000;
            memwb_data     <= 32'd0;
            memwb_misalign <= 1'b0;
        end else if (!stall) begin
            memwb_valid    <= exmem_valid;
            memwb_rd_addr  <= exmem_rd_addr;
            memwb_byte_en  <= be_p0;
            memwb_data     <= data_p0;
            memwb_misalign <= mis_p0;
            if (retire_p0) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected outputs queued per step, popped after the edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        exmem_valid, exmem_mem_read;
    logic [4:0]  exmem_rd_addr;
    logic [3:0]  exmem_byte_en;
    logic [31:0] exmem_result, dmem_rdata;
    logic [2:0]  exmem_load_op;
    logic        memwb_valid, memwb_misalign;
    logic [4:0]  memwb_rd_addr;
    logic [3:0]  memwb_byte_en;
    logic [31:0] memwb_data, retire_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [3:0]  be;
        logic [31:0] data;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.ZERO_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .exmem_valid(exmem_valid), .exmem_rd_addr(exmem_rd_addr),
        .exmem_byte_en(exmem_byte_en), .exmem_result(exmem_result),
        .exmem_mem_read(exmem_mem_read), .exmem_load_op(exmem_load_op),
        .dmem_rdata(dmem_rdata),
        .memwb_valid(memwb_valid), .memwb_rd_addr(memwb_rd_addr),
        .memwb_byte_en(memwb_byte_en), .memwb_data(memwb_data),
        .memwb_misalign(memwb_misalign), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, check them after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic v, input logic [4:0] rd, input logic [3:0] be,
                        input logic [31:0] res, input logic mr, input logic [2:0] op,
                        input logic [31:0] rdata, input exp_t e);
        exp_t got;
        rst = r; stall = s; flush = f;
        exmem_valid = v; exmem_rd_addr = rd; exmem_byte_en = be;
        exmem_result = res; exmem_mem_read = mr; exmem_load_op = op; dmem_rdata = rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".valid"},    {31'd0, memwb_valid},    {31'd0, got.valid});
        chk({tag, ".rd"},       {27'd0, memwb_rd_addr},  {27'd0, got.rd});
        chk({tag, ".be"},       {28'd0, memwb_byte_en},  {28'd0, got.be});
        chk({tag, ".data"},     memwb_data,              got.data);
        chk({tag, ".misalign"}, {31'd0, memwb_misalign}, {31'd0, got.mis});
        chk({tag, ".cnt"},      retire_cnt,              got.cnt);
    endtask

    function automatic exp_t mk(input logic v, input logic [4:0] rd, input logic [3:0] be,
                                input logic [31:0] d, input logic m, input logic [31:0] c);
        exp_t e;
        e.valid = v; e.rd = rd; e.be = be; e.data = d; e.mis = m; e.cnt = c;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        //    tag         rst  stl  fl   v    rd     be       result         mr   op      rdata
        step("reset",     1,   0,   0,   1,   5'd5,  4'hF,    32'h1234_5678, 0,   3'd0,   32'h0,
             mk(0, 0, 4'h0, 32'h0, 0, 0));
        step("alu",       0,   0,   0,   1,   5'd5,  4'hF,    32'h1234_5678, 0,   3'd0,   32'h0,
             mk(1, 5, 4'hF, 32'h1234_5678, 0, 1));
        step("lb_a2",     0,   0,   0,   1,   5'd7,  4'h0,    32'h1000_0002, 1,   3'd1,   32'h0080_0000,
             mk(1, 7, 4'hF, 32'hFFFF_FF80, 0, 2));
        step("lbu_a2",    0,   0,   0,   1,   5'd7,  4'h0,    32'h1000_0002, 1,   3'd2,   32'h0080_0000,
             mk(1, 7, 4'hF, 32'h0000_0080, 0, 3));
        step("lwl_a1",    0,   0,   0,   1,   5'd8,  4'h0,    32'h2000_0001, 1,   3'd5,   32'hAABB_CCDD,
             mk(1, 8, 4'hC, 32'hCCDD_0000, 0, 4));
        step("lwr_a1",    0,   0,   0,   1,   5'd8,  4'h0,    32'h2000_0001, 1,   3'd6,   32'hAABB_CCDD,
             mk(1, 8, 4'h7, 32'h00AA_BBCC, 0, 5));
        step("lh_a2",     0,   0,   0,   1,   5'd4,  4'h0,    32'h2000_0002, 1,   3'd3,   32'h8001_0000,
             mk(1, 4, 4'hF, 32'hFFFF_8001, 0, 6));
        step("lhu_a0",    0,   0,   0,   1,   5'd4,  4'h0,    32'h2000_0000, 1,   3'd4,   32'h1234_F00D,
             mk(1, 4, 4'hF, 32'h0000_F00D, 0, 7));
        step("lw_mis",    0,   0,   0,   1,   5'd9,  4'h0,    32'h2000_0002, 1,   3'd0,   32'hDEAD_BEEF,
             mk(1, 9, 4'h0, 32'hDEAD_BEEF, 1, 7));
        step("lh_mis",    0,   0,   0,   1,   5'd9,  4'h0,    32'h2000_0003, 1,   3'd3,   32'h1122_3344,
             mk(1, 9, 4'h0, 32'h1122_3344, 1, 7));
        step("rd0",       0,   0,   0,   1,   5'd0,  4'hF,    32'h0000_0055, 0,   3'd0,   32'h0,
             mk(1, 0, 4'h0, 32'h0000_0055, 0, 8));
        step("invalid",   0,   0,   0,   0,   5'd3,  4'hF,    32'h0000_0077, 0,   3'd0,   32'h0,
             mk(0, 3, 4'h0, 32'h0000_0077, 0, 8));
        step("alu_be3",   0,   0,   0,   1,   5'd10, 4'h3,    32'hCAFE_BABE, 0,   3'd0,   32'h0,
             mk(1, 10, 4'h3, 32'hCAFE_BABE, 0, 9));
        for (int i = 0; i < 3; i++) begin
            step("stall",  0,  1,   0,   1,   5'(i + 1), 4'hF, $urandom,     0,   3'd0,   32'h0,
                 mk(1, 10, 4'h3, 32'hCAFE_BABE, 0, 9));
        end
        step("stall_flush",0,  1,   1,   1,   5'd11, 4'hF,    32'h1111_1111, 0,   3'd0,   32'h0,
             mk(0, 0, 4'h0, 32'h0, 0, 9));
        step("lwl_a3",    0,   0,   0,   1,   5'd12, 4'h0,    32'h3000_0003, 1,   3'd5,   32'h1122_3344,
             mk(1, 12, 4'hF, 32'h1122_3344, 0, 10));
        step("lwr_a3",    0,   0,   0,   1,   5'd12, 4'h0,    32'h3000_0003, 1,   3'd6,   32'h1122_3344,
             mk(1, 12, 4'h1, 32'h0000_0011, 0, 11));
        step("lwl_a0",    0,   0,   0,   1,   5'd12, 4'h0,    32'h3000_0000, 1,   3'd5,   32'h1122_3344,
             mk(1, 12, 4'h8, 32'h4400_0000, 0, 12));
        step("lb_a3",     0,   0,   0,   1,   5'd13, 4'h0,    32'h3000_0003, 1,   3'd1,   32'h7F00_0000,
             mk(1, 13, 4'hF, 32'h0000_007F, 0, 13));
        step("rsv_a1",    0,   0,   0,   1,   5'd14, 4'h0,    32'h3000_0001, 1,   3'd7,   32'h5566_7788,
             mk(1, 14, 4'h0, 32'h5566_7788, 1, 13));
        step("rsv_a0",    0,   0,   0,   1,   5'd14, 4'h0,    32'h3000_0000, 1,   3'd7,   32'h5566_7788,
             mk(1, 14, 4'hF, 32'h5566_7788, 0, 14));
        step("flush",     0,   0,   1,   1,   5'd15, 4'hF,    32'h2222_2222, 0,   3'd0,   32'h0,
             mk(0, 0, 4'h0, 32'h0, 0, 14));

        force dut.retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt;
        step("cnt_max",   0,   0,   0,   1,   5'd16, 4'hF,    32'h0000_00AA, 0,   3'd0,   32'h0,
             mk(1, 16, 4'hF, 32'h0000_00AA, 0, 32'hFFFF_FFFF));
        step("cnt_wrap",  0,   0,   0,   1,   5'd17, 4'hF,    32'h0000_00BB, 0,   3'd0,   32'h0,
             mk(1, 17, 4'hF, 32'h0000_00BB, 0, 0));
        step("alu_pre",   0,   0,   0,   1,   5'd18, 4'hF,    32'h0000_00CC, 0,   3'd0,   32'h0,
             mk(1, 18, 4'hF, 32'h0000_00CC, 0, 1));
        step("rst_mid",   1,   1,   1,   1,   5'd19, 4'hF,    32'h0000_00DD, 0,   3'd0,   32'h0,
             mk(0, 0, 4'h0, 32'h0, 0, 0));
        step("post_rst",  0,   0,   0,   1,   5'd20, 4'hF,    32'h0000_00EE, 0,   3'd0,   32'h0,
             mk(1, 20, 4'hF, 32'h0000_00EE, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
